// File: rtl/i2c_frame_counter.sv
// SCL-domain bit/word counter for the I2C subordinate datapath.
// Optional per-frame word limit enabled by defining I2C_WORD_LIMIT_EN.
module i2c_frame_counter #(
   parameter int WORD_BITS = 8,
   parameter int BIT_W     = 4,
   parameter int WORD_W    = 8,
   parameter int MAX_WORDS = 16
) (
   input  logic              scl,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   output logic [BIT_W-1:0]  count,
   output logic              ack_slot,
   output logic              word_done,
   output logic [WORD_W-1:0] word_cnt,
   output logic              active,
   output logic              first_word,
   output logic              limit_hit
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FRAME = 2'd1;
`ifdef I2C_WORD_LIMIT_EN
   localparam logic [1:0] S_LIMIT = 2'd2;
   // word_cnt value just before the ACK edge that reaches the limit
   localparam logic [WORD_W-1:0] LIMIT_PREV = WORD_W'(MAX_WORDS - 1);
`endif
   localparam logic [BIT_W-1:0] ACK_POS = BIT_W'(WORD_BITS);

   logic [1:0] state;
`ifdef I2C_WORD_LIMIT_EN
   logic       limit_q;
`endif

   // Frame state, bit position and word count; start beats stop beats counting
   always_ff @(posedge scl or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         count     <= '0;
         word_cnt  <= '0;
         word_done <= 1'b0;
`ifdef I2C_WORD_LIMIT_EN
         limit_q   <= 1'b0;
`endif
      end else begin
         word_done <= 1'b0;
         if (start) begin
            state    <= S_FRAME;
            count    <= '0;
            word_cnt <= '0;
`ifdef I2C_WORD_LIMIT_EN
            limit_q  <= 1'b0;
`endif
         end else if (stop && state != S_IDLE) begin
            state   <= S_IDLE;
            count   <= '0;
`ifdef I2C_WORD_LIMIT_EN
            limit_q <= 1'b0;
`endif
         end else if (state == S_FRAME) begin
            if (count == ACK_POS) begin
               count     <= '0;
               word_cnt  <= word_cnt + WORD_W'(1);
               word_done <= 1'b1;
`ifdef I2C_WORD_LIMIT_EN
               if (word_cnt == LIMIT_PREV) begin
                  state   <= S_LIMIT;
                  limit_q <= 1'b1;
               end
`endif
            end else begin
               count <= count + BIT_W'(1);
            end
         end
      end
   end

   // Status decode from registered state only
   always_comb begin
      active     = (state != S_IDLE);
      ack_slot   = (state == S_FRAME) && (count == ACK_POS);
      first_word = active && (word_cnt == '0);
`ifdef I2C_WORD_LIMIT_EN
      limit_hit  = limit_q;
`else
      limit_hit  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_i2c_frame_counter.sv
// Scoreboard bench for i2c_frame_counter: a behavioural model pushes
// the expected output vector per edge, popped and compared after it.
module tb_i2c_frame_counter;

   localparam int WB  = 8;
   localparam int WW  = 2;
   localparam int MXW = 2;

   logic       scl = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] count;
   logic       ack_slot, word_done, active, first_word, limit_hit;
   logic [1:0] word_cnt;

   int n_chk = 0;
   int n_err = 0;

   logic [10:0] exp_q[$];

   int m_state = 0;
   int m_count = 0;
   int m_words = 0;
   bit m_done  = 0;
   bit m_lim   = 0;

   i2c_frame_counter #(
      .WORD_BITS(WB), .BIT_W(4), .WORD_W(WW), .MAX_WORDS(MXW)
   ) dut (
      .scl(scl), .rst(rst), .start(start), .stop(stop),
      .count(count), .ack_slot(ack_slot), .word_done(word_done),
      .word_cnt(word_cnt), .active(active), .first_word(first_word),
      .limit_hit(limit_hit)
   );

   always #5 scl = ~scl;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [10:0] got,
                        input logic [10:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %b want %b", tag, got, want);
      end
   endtask

   function automatic logic [10:0] dut_vec();
      return {count, ack_slot, word_done, word_cnt,
              active, first_word, limit_hit};
   endfunction

   function automatic logic [10:0] model_vec();
      bit act;
      act = (m_state != 0);
      return {4'(m_count), (m_state == 1) && (m_count == WB), m_done,
              2'(m_words), act, act && (m_words == 0), m_lim};
   endfunction

   task automatic model_reset();
      m_state = 0; m_count = 0; m_words = 0; m_done = 0; m_lim = 0;
   endtask

   task automatic model_step(input bit s, input bit p);
      m_done = 0;
      if (s) begin
         m_state = 1; m_count = 0; m_words = 0; m_lim = 0;
      end else if (p && m_state != 0) begin
         m_state = 0; m_count = 0; m_lim = 0;
      end else if (m_state == 1) begin
         if (m_count == WB) begin
            m_count = 0;
            m_words = (m_words + 1) % (1 << WW);
            m_done  = 1;
`ifdef I2C_WORD_LIMIT_EN
            if (m_words == MXW) begin
               m_state = 2; m_lim = 1;
            end
`endif
         end else begin
            m_count++;
         end
      end
   endtask

   task automatic edge_chk(input string tag, input bit s, input bit p);
      start = s;
      stop  = p;
      model_step(s, p);
      exp_q.push_back(model_vec());
      @(posedge scl);
      #1;
      check(tag, dut_vec(), exp_q.pop_front());
   endtask

   task automatic edges(input string tag, input int n);
      for (int i = 0; i < n; i++) edge_chk(tag, 1'b0, 1'b0);
   endtask

   initial begin
      model_reset();
      #2;
      exp_q.push_back(model_vec());
      check("reset", dut_vec(), exp_q.pop_front());
      @(negedge scl);
      rst = 1'b1;

      edges("idle", 3);

      edge_chk("rst_start", 1'b1, 1'b0);
      edges("rst_cnt", 5);
      check("rst_at5", {7'd0, count}, 11'd5);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      exp_q.push_back(model_vec());
      check("rst_mid", dut_vec(), exp_q.pop_front());
      @(negedge scl);
      rst = 1'b1;
      edges("rst_idle", 4);

      edge_chk("two_start", 1'b1, 1'b0);
      edges("two_words", 18);
      check("two_wcnt", {9'd0, word_cnt}, 11'd2);

      edge_chk("rs_start", 1'b1, 1'b0);
      edges("rs_pre", 14);
      edge_chk("rs_again", 1'b1, 1'b0);
      check("rs_state", {9'd0, active, first_word}, 11'b11);
      edges("rs_post", 3);

      edge_chk("stop_start", 1'b1, 1'b0);
      edges("stop_pre", 12);
      edge_chk("stop", 1'b0, 1'b1);
      check("stop_wcnt", {9'd0, word_cnt}, 11'd1);
      edges("stop_idle", 20);

      edge_chk("hold_stop", 1'b0, 1'b1);
      edge_chk("hold_stop", 1'b0, 1'b1);
      edge_chk("both", 1'b1, 1'b1);
      check("both_cnt", {6'd0, active, count}, {6'd0, 1'b1, 4'd0});
      edges("both_post", 9);
      check("both_wcnt", {9'd0, word_cnt}, 11'd1);

      edge_chk("lim_start", 1'b1, 1'b0);
      edges("lim_run", 36);
`ifdef I2C_WORD_LIMIT_EN
      check("lim_end", {8'd0, word_cnt, limit_hit}, {8'd0, 2'd2, 1'b1});
`else
      check("wrap_end", {8'd0, word_cnt, limit_hit}, 11'd0);
`endif
      edges("lim_more", 10);
      edge_chk("lim_stop", 1'b0, 1'b1);
      check("lim_clear", {9'd0, active, limit_hit}, 11'd0);
      edges("lim_idle", 3);

      if (exp_q.size() != 0) begin
         n_chk++;
         n_err++;
         $display("FAIL queue: got %0d left want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
